// File: rtl/ice40_spi_sysbus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ice40_spi_sysbus_arbiter_pkg
// Brief    : SB_SPI register map and system-bus arbiter state encodings.
// Revision : 1.0  initial release
// ============================================================================
package ice40_spi_sysbus_arbiter_pkg;

    // SB_SPI register offsets (low nibble of SBADRI)
    localparam logic [7:0] SPI_ADDR_CR0  = 8'h08;
    localparam logic [7:0] SPI_ADDR_CR1  = 8'h09;
    localparam logic [7:0] SPI_ADDR_CR2  = 8'h0A;
    localparam logic [7:0] SPI_ADDR_BR   = 8'h0B;
    localparam logic [7:0] SPI_ADDR_SR   = 8'h0C;
    localparam logic [7:0] SPI_ADDR_TXDR = 8'h0D;
    localparam logic [7:0] SPI_ADDR_RXDR = 8'h0E;
    localparam logic [7:0] SPI_ADDR_CSR  = 8'h0F;

    typedef enum logic [1:0] {
        SPIARB_IDLE   = 2'd0,
        SPIARB_ACCESS = 2'd1,
        SPIARB_TURN   = 2'd2,
        SPIARB_LOCKED = 2'd3
    } spiarb_state_e;

endpackage
`default_nettype wire

// File: rtl/ice40_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ice40_rr_arbiter
// Brief    : Combinational round-robin select: first set request at or after ptr.
// Revision : 1.0  initial release
// ============================================================================
module ice40_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        int cand;
        cand = 0;
        idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (req[IW'(cand)]) idx = IW'(cand);
        end
    end

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/ice40_spi_sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ice40_spi_sysbus_arbiter
// Brief    : Round-robin sharing of the SB_SPI system bus with lock and ack timeout.
// Revision : 1.0  initial release
// ============================================================================
module ice40_spi_sysbus_arbiter
    import ice40_spi_sysbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_strobe,
    input  logic [NUM_REQ-1:0]         req_rw,
    input  logic [8*NUM_REQ-1:0]       req_addr,
    input  logic [8*NUM_REQ-1:0]       req_data_in,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         req_err,
    output logic [7:0]                 req_data_out,
    output logic                       spi_strobe,
    output logic                       spi_rw,
    output logic [7:0]                 spi_addr,
    output logic [7:0]                 spi_data_in,
    input  logic [7:0]                 spi_data_out,
    input  logic                       spi_ack,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
    localparam logic [GW-1:0] LAST_IDX    = GW'(NUM_REQ - 1);

    spiarb_state_e        state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 timed_out_q, timed_out_d;
    logic                 spi_strobe_q, spi_strobe_d;
    logic                 spi_rw_q, spi_rw_d;
    logic [7:0]           spi_addr_q, spi_addr_d;
    logic [7:0]           spi_data_in_q, spi_data_in_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]   req_err_q, req_err_d;
    logic [7:0]           req_data_out_q, req_data_out_d;
    logic                 busy_q, busy_d;

    logic [GW-1:0]        arb_idx;
    logic                 arb_valid;
    logic [GW-1:0]        sel_idx;
    logic                 sel_rw;
    logic [7:0]           sel_addr;
    logic [7:0]           sel_data;
    logic [CW-1:0]        cnt_inc;
    logic [GW-1:0]        next_ptr;

    ice40_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_rr (
        .req   (req_strobe),
        .ptr   (rr_ptr_q),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Outside IDLE the bus always belongs to the latched owner.
    assign sel_idx  = (state_q == SPIARB_IDLE) ? arb_idx : grant_q;
    assign sel_rw   = req_rw[sel_idx];
    assign sel_addr = req_addr[{sel_idx, 3'b000} +: 8];
    assign sel_data = req_data_in[{sel_idx, 3'b000} +: 8];
    assign cnt_inc  = (cnt_q == TIMEOUT_CNT) ? cnt_q : cnt_q + 1'b1;
    assign next_ptr = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        timed_out_d    = timed_out_q;
        spi_strobe_d   = spi_strobe_q;
        spi_rw_d       = spi_rw_q;
        spi_addr_d     = spi_addr_q;
        spi_data_in_d  = spi_data_in_q;
        req_ack_d      = '0;
        req_err_d      = '0;
        req_data_out_d = req_data_out_q;

        case (state_q)
            SPIARB_IDLE: begin
                if (arb_valid) begin
                    grant_d       = arb_idx;
                    spi_strobe_d  = 1'b1;
                    spi_rw_d      = sel_rw;
                    spi_addr_d    = sel_addr;
                    spi_data_in_d = sel_data;
                    cnt_d         = '0;
                    state_d       = SPIARB_ACCESS;
                end
            end
            SPIARB_ACCESS: begin
                spi_strobe_d  = 1'b1;
                spi_rw_d      = sel_rw;
                spi_addr_d    = sel_addr;
                spi_data_in_d = sel_data;
                cnt_d         = cnt_inc;
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (spi_ack) begin
                    spi_strobe_d       = 1'b0;
                    req_ack_d[grant_q] = 1'b1;
                    req_data_out_d     = spi_data_out;
                    rr_ptr_d           = next_ptr;
                    timed_out_d        = 1'b0;
                    state_d            = SPIARB_TURN;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    spi_strobe_d       = 1'b0;
                    req_err_d[grant_q] = 1'b1;
                    timed_out_d        = 1'b1;
                    state_d            = SPIARB_TURN;
                end
            end
            SPIARB_TURN: begin
                state_d = (req_lock[grant_q] && !timed_out_q) ? SPIARB_LOCKED : SPIARB_IDLE;
            end
            SPIARB_LOCKED: begin
                if (req_strobe[grant_q]) begin
                    spi_strobe_d  = 1'b1;
                    spi_rw_d      = sel_rw;
                    spi_addr_d    = sel_addr;
                    spi_data_in_d = sel_data;
                    cnt_d         = '0;
                    state_d       = SPIARB_ACCESS;
                end else if (!req_lock[grant_q]) begin
                    state_d = SPIARB_IDLE;
                end
            end
            default: state_d = SPIARB_IDLE;
        endcase

        busy_d = (state_d != SPIARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SPIARB_IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
            timed_out_q    <= 1'b0;
            spi_strobe_q   <= 1'b0;
            spi_rw_q       <= 1'b0;
            spi_addr_q     <= '0;
            spi_data_in_q  <= '0;
            req_ack_q      <= '0;
            req_err_q      <= '0;
            req_data_out_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            timed_out_q    <= timed_out_d;
            spi_strobe_q   <= spi_strobe_d;
            spi_rw_q       <= spi_rw_d;
            spi_addr_q     <= spi_addr_d;
            spi_data_in_q  <= spi_data_in_d;
            req_ack_q      <= req_ack_d;
            req_err_q      <= req_err_d;
            req_data_out_q <= req_data_out_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ack      = req_ack_q;
    assign req_err      = req_err_q;
    assign req_data_out = req_data_out_q;
    assign spi_strobe   = spi_strobe_q;
    assign spi_rw       = spi_rw_q;
    assign spi_addr     = spi_addr_q;
    assign spi_data_in  = spi_data_in_q;
    assign grant        = grant_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ice40_spi_sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ice40_spi_sysbus_arbiter
// Brief    : Directed self-checking bench for the SB_SPI system-bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_ice40_spi_sysbus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_strobe;
    logic [1:0]  req_rw;
    logic [15:0] req_addr;
    logic [15:0] req_data_in;
    logic [1:0]  req_lock;
    logic [1:0]  req_ack;
    logic [1:0]  req_err;
    logic [7:0]  req_data_out;
    logic        spi_strobe;
    logic        spi_rw;
    logic [7:0]  spi_addr;
    logic [7:0]  spi_data_in;
    logic [7:0]  spi_data_out;
    logic        spi_ack;
    logic [0:0]  grant;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int n;

    ice40_spi_sysbus_arbiter #(
        .NUM_REQ (2),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_strobe   (req_strobe),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_data_in  (req_data_in),
        .req_lock     (req_lock),
        .req_ack      (req_ack),
        .req_err      (req_err),
        .req_data_out (req_data_out),
        .spi_strobe   (spi_strobe),
        .spi_rw       (spi_rw),
        .spi_addr     (spi_addr),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_ack      (spi_ack),
        .grant        (grant),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered on the first strobe cycle; returns on the TURN cycle.
    task automatic serve(input int ack_at, input logic [7:0] rdata, output int cycles);
        cycles = 0;
        while (spi_strobe && cycles < 40) begin
            cycles++;
            if (cycles == ack_at) begin
                spi_ack      = 1'b1;
                spi_data_out = rdata;
            end
            step();
            spi_ack      = 1'b0;
            spi_data_out = 8'hEE;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_strobe   = '0;
        req_rw       = '0;
        req_addr     = '0;
        req_data_in  = '0;
        req_lock     = '0;
        spi_ack      = 1'b0;
        spi_data_out = 8'hEE;
        do_reset();

        check_vec("rst_strobe", spi_strobe, 0);
        check_vec("rst_busy",   busy,       0);
        check_vec("rst_grant",  grant,      0);
        check_vec("rst_ack",    req_ack,    0);
        check_vec("rst_err",    req_err,    0);

        // Single client write CR0 <= C0, ack on 3rd strobe cycle
        req_rw[0]        = 1'b1;
        req_addr[7:0]    = 8'h08;
        req_data_in[7:0] = 8'hC0;
        req_strobe       = 2'b01;
        step();
        check_vec("t1_strobe", spi_strobe,  1);
        check_vec("t1_rw",     spi_rw,      1);
        check_vec("t1_addr",   spi_addr,    8'h08);
        check_vec("t1_wdata",  spi_data_in, 8'hC0);
        check_vec("t1_grant",  grant,       0);
        check_vec("t1_busy",   busy,        1);
        serve(3, 8'h00, n);
        check_vec("t1_cycles",      n,          3);
        check_vec("t1_ack",         req_ack,    2'b01);
        check_vec("t1_err",         req_err,    2'b00);
        check_vec("t1_turn_strobe", spi_strobe, 0);
        check_vec("t1_turn_busy",   busy,       1);
        step();
        check_vec("t1_idle_busy",   busy,       0);
        check_vec("t1_idle_strobe", spi_strobe, 0);
        check_vec("t1_ack_pulse",   req_ack,    2'b00);
        req_strobe = 2'b00;
        step();
        check_vec("t1_no_reissue", spi_strobe, 0);

        // Contention from pointer 0: grants alternate
        do_reset();
        req_rw      = 2'b00;
        req_addr    = {8'h0F, 8'h0E};
        req_strobe  = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            check_vec("t2_grant",  grant,      k % 2);
            check_vec("t2_addr",   spi_addr,   (k % 2) ? 8'h0F : 8'h0E);
            serve(2, 8'h10 + 8'(k), n);
            check_vec("t2_ack",    req_ack,    (k % 2) ? 2'b10 : 2'b01);
            check_vec("t2_rdata",  req_data_out, 8'h10 + 8'(k));
            step();
            check_vec("t2_idle",   busy,       0);
            if (k == 3) req_strobe = 2'b00;
            step();
        end
        check_vec("t2_end_strobe", spi_strobe, 0);

        // Lock: client1 reads SR then writes TXDR while client0 waits
        req_rw[1]         = 1'b0;
        req_addr[15:8]    = 8'h0C;
        req_lock          = 2'b10;
        req_strobe        = 2'b10;
        step();
        check_vec("t3_grant_a", grant,    1);
        check_vec("t3_addr_sr", spi_addr, 8'h0C);
        req_strobe = 2'b11;
        serve(1, 8'h5A, n);
        check_vec("t3_ack_sr",  req_ack,      2'b10);
        check_vec("t3_sr_data", req_data_out, 8'h5A);
        step();
        check_vec("t3_locked_busy",   busy,       1);
        check_vec("t3_locked_strobe", spi_strobe, 0);
        req_strobe = 2'b01;
        step();
        check_vec("t3_hold_grant",  grant,      1);
        check_vec("t3_hold_strobe", spi_strobe, 0);
        req_rw[1]          = 1'b1;
        req_addr[15:8]     = 8'h0D;
        req_data_in[15:8]  = 8'hA5;
        req_strobe         = 2'b11;
        step();
        check_vec("t3_grant_b", grant,       1);
        check_vec("t3_addr_tx", spi_addr,    8'h0D);
        check_vec("t3_wdata",   spi_data_in, 8'hA5);
        check_vec("t3_rw",      spi_rw,      1);
        serve(2, 8'h00, n);
        check_vec("t3_ack_tx", req_ack, 2'b10);
        step();
        req_strobe = 2'b01;
        req_lock   = 2'b00;
        step();
        check_vec("t3_unlock_idle", busy, 0);
        step();
        check_vec("t3_grant_c", grant,    0);
        check_vec("t3_addr_c",  spi_addr, 8'h0E);
        serve(1, 8'h77, n);
        check_vec("t3_ack_c", req_ack, 2'b01);
        step();
        req_strobe = 2'b00;
        step();
        check_vec("t3_end_busy", busy, 0);

        // Timeout with lock requested: lock must be ignored
        req_lock   = 2'b01;
        req_strobe = 2'b01;
        step();
        check_vec("t4_grant", grant, 0);
        serve(0, 8'h00, n);
        check_vec("t4_cycles", n,       4);
        check_vec("t4_err",    req_err, 2'b01);
        check_vec("t4_no_ack", req_ack, 2'b00);
        step();
        check_vec("t4_idle",      busy,    0);
        check_vec("t4_err_pulse", req_err, 2'b00);
        req_strobe = 2'b00;
        req_lock   = 2'b00;
        step();
        check_vec("t4_end_strobe", spi_strobe, 0);

        // Ack coinciding with the timeout cycle wins
        req_strobe = 2'b01;
        step();
        serve(4, 8'h3C, n);
        check_vec("t6_cycles", n,            4);
        check_vec("t6_ack",    req_ack,      2'b01);
        check_vec("t6_no_err", req_err,      2'b00);
        check_vec("t6_rdata",  req_data_out, 8'h3C);
        step();
        req_strobe = 2'b00;
        step();

        // Reset in the middle of an access by client1
        req_strobe = 2'b10;
        step();
        check_vec("t5_pre_strobe", spi_strobe, 1);
        check_vec("t5_pre_grant",  grant,      1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_vec("t5_strobe", spi_strobe,  0);
        check_vec("t5_grant",  grant,       0);
        check_vec("t5_busy",   busy,        0);
        check_vec("t5_addr",   spi_addr,    0);
        check_vec("t5_rw",     spi_rw,      0);
        check_vec("t5_wdata",  spi_data_in, 0);
        check_vec("t5_ack",    req_ack,     0);
        check_vec("t5_err",    req_err,     0);
        req_strobe = 2'b11;
        step();
        check_vec("t5_regrant", grant,      0);
        check_vec("t5_restart", spi_strobe, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ice40_spi_sysbus_arbiter.md
Name: ice40_spi_sysbus_arbiter

Overview:
Shares the single SB_SPI hard-IP system bus (strobe/ack/rw/addr/data) between NUM_REQ register-level clients, e.g. the master SPI controller plus a flash-readback or debug client. Round-robin grant at transaction granularity, optional lock for multi-access sequences (poll SR, then write TXDR), and an ack-timeout watchdog. Sits between the clients and the SB_SPI primitive wrapper; the clients keep their existing strobe-until-ack protocol unchanged.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT, 255, cycles without spi_ack before a granted access is aborted (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
req_strobe  in  NUM_REQ  per-client access request, held until its ack
req_rw  in  NUM_REQ  per-client 1=write, 0=read
req_addr  in  8*NUM_REQ  per-client register address, client i at [8i+7:8i]
req_data_in  in  8*NUM_REQ  per-client write data
req_lock  in  NUM_REQ  keep grant after this client's ack
req_ack  out  NUM_REQ  one-cycle ack routed to the granted client only
req_err  out  NUM_REQ  one-cycle timeout pulse to the granted client
req_data_out  out  8  read data, broadcast; valid with req_ack
spi_strobe  out  1  to SB_SPI SBSTBI
spi_rw  out  1  to SBRWI
spi_addr  out  8  to SBADRI
spi_data_in  out  8  to SBDATI
spi_data_out  in  8  from SBDATO
spi_ack  in  1  from SBACKO
grant  out  $clog2(NUM_REQ)  index of current/last owner
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, takes effect mid-transaction too): state=IDLE, grant=0, rr pointer=0, timeout count=0; spi_strobe=0, spi_rw=0, spi_addr=0, spi_data_in=0, req_ack=0, req_err=0, busy=0.
- All SB_SPI-side outputs are registered. req_ack, req_err and req_data_out are registered one cycle after spi_ack or the timeout.
- States: IDLE, ACCESS, TURN, LOCKED.
- IDLE: if any req_strobe is set, pick the first set bit at or after rr pointer, wrapping modulo NUM_REQ. Latch grant, drive spi_* from that client's rw/addr/data with spi_strobe=1, then go to ACCESS. Nothing set: stay.
- ACCESS: keep spi_strobe=1 and re-sample the granted client's fields each cycle. Count cycles.
  - On spi_ack: spi_strobe<=0, req_ack[grant]<=1, req_data_out<=spi_data_out, rr pointer<=grant+1 (wrap), go to TURN.
  - On count==TIMEOUT with no ack: spi_strobe<=0, req_err[grant]<=1, go to TURN; the lock is ignored.
  - An ack arriving in the same cycle as the timeout wins.
- TURN (exactly 1 cycle): spi_strobe held 0 and req_strobe masked. This absorbs the client's still-high strobe in the cycle after its ack, so the same access is never re-issued.
  - Exit to LOCKED if req_lock[grant]=1 and the exit was not a timeout; otherwise to IDLE.
- LOCKED: other clients are blocked.
  - If req_strobe[grant]: issue the access and go to ACCESS, count cleared.
  - Else if req_lock[grant]=0: go to IDLE.
- Starvation bound: without locks, each client waits at most NUM_REQ-1 transactions.
- req_ack and req_err are never asserted in the same cycle. At most one bit of req_ack|req_err is set per cycle.
- A client dropping req_strobe before ack during ACCESS is a protocol violation. The access completes anyway and the ack is still delivered.
- Timeout count width is $clog2(TIMEOUT+1). Saturating; cleared on every entry to ACCESS.

Decomposition:
- Shared package/header: extend spi/ice40_spi.vh with the state encodings (SPIARB_IDLE/ACCESS/TURN/LOCKED) next to the existing SPI register address defines. No new address constants are needed.
- One natural sub-module: ice40_rr_arbiter. It is combinational round-robin priority select (request vector, pointer → index, valid) and is reusable for the I2C hard-IP bus.

Test Plan:
- Single client: req0 write addr 0x08 data 0xC0, spi_ack after 3 cycles. Expect spi_strobe high 3 cycles, req_ack[0] one cycle later, one TURN cycle with spi_strobe=0, then IDLE, busy=0.
- Contention: req0 and req1 strobe together, repeating with rr pointer 0. Expect grants 0,1,0,1 and no back-to-back grant to the same client.
- Lock: client1 sets req_lock and issues SR read (0x0C), then TXDR write (0x0D) while client0 requests continuously. Expect client0 granted only after client1 drops lock; req_data_out = SR value on the first ack.
- Timeout: TIMEOUT=4, spi_ack never asserted. Expect spi_strobe for 4 cycles, req_err[grant] one pulse, no req_ack, lock ignored, return to IDLE.
- Reset mid-ACCESS: assert reset with spi_strobe=1. Next cycle all outputs 0, grant=0, state IDLE. The next request is granted from pointer 0.
- Ack and timeout coincide on the same cycle: expect req_ack only, with valid data, and no req_err.
